axi_stream_receiver: RTL and testbench

Receive side of the 16-bit AXI4-Stream link used for SHA3 state transfer. Accepts beats from a stream source and packs up to eight 16-bit beats into one 128-bit state word (`rxstate`), presented to the downstream core with a valid/ready handshake. Also packs the word's sideband (TID, TDEST, TUSER, TLAST, byte count) and flags protocol errors. Holds one completed word; applies backpressure via TREADY while that word is unconsumed.

---
 rtl/axi_stream_receiver.sv | 155 +++++++++++++++
 tb/tb_axi_stream_receiver.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_receiver.sv
// axi_stream_receiver
// Receive side of the 16-bit AXI4-Stream link for SHA3 state transfer.
// Packs up to BEATS beats of DATA_W bits into one WORD_W word and hands it
// downstream with a valid/ready handshake. One completed word is held; the
// stream is backpressured (TREADY=0) until that word is consumed.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   TVALID/TREADY/TDATA   stream beat handshake and data (lane 0 = [7:0])
//   TKEEP/TSTRB           per-byte present / per-byte data qualifiers
//   TID/TDEST/TUSER/TLAST stream sideband
//   rxstate, rx_valid     assembled word and its valid flag
//   rx_ready              downstream consumes the held word
//   rx_bytes              kept-byte count of the word (0..16)
//   rx_last               word was closed by TLAST
//   rx_tid, rx_dest       sideband of the word's first beat
//   rx_user               OR of TUSER over the word's beats
//   rx_err                protocol error seen inside the word
module axi_stream_receiver #(
   parameter int DATA_W = 16,
   parameter int WORD_W = 128
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                TVALID,
   output logic                TREADY,
   input  logic [DATA_W-1:0]   TDATA,
   input  logic [DATA_W/8-1:0] TKEEP,
   input  logic [DATA_W/8-1:0] TSTRB,
   input  logic [6:0]          TID,
   input  logic                TDEST,
   input  logic                TUSER,
   input  logic                TLAST,
   output logic [WORD_W-1:0]   rxstate,
   output logic                rx_valid,
   input  logic                rx_ready,
   output logic [4:0]          rx_bytes,
   output logic                rx_last,
   output logic [6:0]          rx_tid,
   output logic                rx_dest,
   output logic                rx_user,
   output logic                rx_err
);

   localparam int NB    = DATA_W / 8;
   localparam int BEATS = WORD_W / DATA_W;
   localparam int KW    = $clog2(BEATS);

   typedef enum logic {COLLECT, HOLD} state_e;

   state_e            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [4:0]        bytes_q, bytes_d;
   logic              last_q, last_d;
   logic [6:0]        tid_q, tid_d;
   logic              dest_q, dest_d;
   logic              user_q, user_d;
   logic              err_q, err_d;

   logic              accept;
   logic              beat_last;
   logic [DATA_W-1:0] lane;
   logic [4:0]        kept;

   // TREADY depends only on state and reset, never on rx_ready.
   assign TREADY = !ARESET && (state_q == COLLECT);
   assign accept = TVALID && TREADY;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      word_d    = word_q;
      bytes_d   = bytes_q;
      last_d    = last_q;
      tid_d     = tid_q;
      dest_d    = dest_q;
      user_d    = user_q;
      err_d     = err_q;
      beat_last = (k_q == KW'(BEATS - 1)) || TLAST;
      lane      = '0;
      kept      = '0;
      // Only bytes that are both kept and data land in the word.
      for (int b = 0; b < NB; b++) begin
         lane[8*b +: 8] = (TKEEP[b] && TSTRB[b]) ? TDATA[8*b +: 8] : 8'h00;
         kept           = kept + 5'(TKEEP[b]);
      end
      case (state_q)
         COLLECT: begin
            if (accept) begin
               // First beat of a word: drop the previous word's contents.
               if (k_q == '0) begin
                  word_d  = '0;
                  bytes_d = '0;
                  err_d   = 1'b0;
                  user_d  = 1'b0;
                  tid_d   = TID;
                  dest_d  = TDEST;
               end
               word_d[int'(k_q)*DATA_W +: DATA_W] = lane;
               bytes_d = bytes_d + kept;
               user_d  = user_d | TUSER;
               if (((k_q != '0) && ((TID != tid_q) || (TDEST != dest_q))) ||
                   (!beat_last && (TKEEP != '1)))
                  err_d = 1'b1;
               if (beat_last) begin
                  last_d  = TLAST;
                  k_d     = '0;
                  state_d = HOLD;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (rx_ready) state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= COLLECT;
         k_q     <= '0;
         word_q  <= '0;
         bytes_q <= '0;
         last_q  <= 1'b0;
         tid_q   <= '0;
         dest_q  <= 1'b0;
         user_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         word_q  <= word_d;
         bytes_q <= bytes_d;
         last_q  <= last_d;
         tid_q   <= tid_d;
         dest_q  <= dest_d;
         user_q  <= user_d;
         err_q   <= err_d;
      end
   end

   assign rxstate  = word_q;
   assign rx_valid = (state_q == HOLD);
   assign rx_bytes = bytes_q;
   assign rx_last  = last_q;
   assign rx_tid   = tid_q;
   assign rx_dest  = dest_q;
   assign rx_user  = user_q;
   assign rx_err   = err_q;

endmodule

// File: tb/tb_axi_stream_receiver.sv
// Testbench for axi_stream_receiver: directed scenarios followed by a
// randomized stream, all outputs compared every cycle against a word-level
// reference model of the receiver.
module tb_axi_stream_receiver;

   logic         ACLK = 1'b0;
   logic         ARESET = 1'b1;
   logic         TVALID = 1'b0;
   logic         TREADY;
   logic [15:0]  TDATA = '0;
   logic [1:0]   TKEEP = '0;
   logic [1:0]   TSTRB = '0;
   logic [6:0]   TID = '0;
   logic         TDEST = 1'b0;
   logic         TUSER = 1'b0;
   logic         TLAST = 1'b0;
   logic [127:0] rxstate;
   logic         rx_valid;
   logic         rx_ready = 1'b0;
   logic [4:0]   rx_bytes;
   logic         rx_last;
   logic [6:0]   rx_tid;
   logic         rx_dest;
   logic         rx_user;
   logic         rx_err;

   axi_stream_receiver dut (
      .ACLK(ACLK), .ARESET(ARESET), .TVALID(TVALID), .TREADY(TREADY),
      .TDATA(TDATA), .TKEEP(TKEEP), .TSTRB(TSTRB), .TID(TID), .TDEST(TDEST),
      .TUSER(TUSER), .TLAST(TLAST), .rxstate(rxstate), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .rx_bytes(rx_bytes), .rx_last(rx_last),
      .rx_tid(rx_tid), .rx_dest(rx_dest), .rx_user(rx_user), .rx_err(rx_err)
   );

   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, obs, exp);
      end
   endtask

   // Reference model: list-of-beats view of the word being built.
   bit           m_hold = 0;
   int           m_nb = 0;
   bit           m_acc = 0;
   logic [127:0] m_state = '0;
   logic [4:0]   m_bytes = '0;
   logic         m_last = 0, m_dest = 0, m_user = 0, m_err = 0;
   logic [6:0]   m_tid = '0;

   task automatic cyc(input logic v, input logic [15:0] d, input logic [1:0] kp,
                      input logic [1:0] st, input logic [6:0] id, input logic de,
                      input logic us, input logic la, input logic rdy, input logic rst);
      logic        exp_rdy;
      logic [15:0] ln;
      bit          fin;
      TVALID = v; TDATA = d; TKEEP = kp; TSTRB = st; TID = id; TDEST = de;
      TUSER = us; TLAST = la; rx_ready = rdy; ARESET = rst;
      #1;
      exp_rdy = !rst && !m_hold;
      chk("tready", TREADY, exp_rdy);
      @(posedge ACLK);
      m_acc = v && exp_rdy;
      if (rst) begin
         m_hold = 0; m_nb = 0; m_state = '0; m_bytes = '0; m_last = 0;
         m_tid = '0; m_dest = 0; m_user = 0; m_err = 0;
      end else if (m_hold) begin
         if (rdy) m_hold = 0;
      end else if (m_acc) begin
         if (m_nb == 0) begin
            m_state = '0; m_bytes = '0; m_err = 0; m_user = 0; m_tid = id; m_dest = de;
         end
         ln = 16'h0;
         if (kp[0] && st[0]) ln = ln + {8'h00, d[7:0]};
         if (kp[1] && st[1]) ln = ln + {d[15:8], 8'h00};
         m_state = m_state | (128'(ln) << (16 * m_nb));
         m_bytes = m_bytes + 5'($countones(kp));
         m_user  = m_user | us;
         fin = (m_nb == 7) || la;
         if (m_nb > 0 && (id != m_tid || de != m_dest)) m_err = 1;
         if (!fin && kp != 2'b11) m_err = 1;
         m_nb++;
         if (fin) begin
            m_hold = 1; m_last = la; m_nb = 0;
         end
      end
      #1;
      chk("rx_valid", rx_valid, m_hold);
      chk("rxstate", rxstate, m_state);
      chk("rx_bytes", rx_bytes, m_bytes);
      chk("rx_last", rx_last, m_last);
      chk("rx_tid", rx_tid, m_tid);
      chk("rx_dest", rx_dest, m_dest);
      chk("rx_user", rx_user, m_user);
      chk("rx_err", rx_err, m_err);
   endtask

   task automatic idle(input logic rdy);
      cyc(0, 16'h0, 2'b00, 2'b00, 7'h0, 0, 0, 0, rdy, 0);
   endtask

   // Present a beat until accepted (downstream not consuming meanwhile).
   task automatic send(input logic [15:0] d, input logic [1:0] kp, input logic [6:0] id,
                       input logic us, input logic la);
      for (int i = 0; i < 20; i++) begin
         cyc(1, d, kp, 2'b11, id, 0, us, la, 0, 0);
         if (m_acc) return;
      end
      chk("send_timeout", 0, 1);
   endtask

   initial begin
      // Reset with TVALID asserted: nothing accepted, outputs zero.
      cyc(1, 16'h1234, 2'b11, 2'b11, 7'h3, 1, 1, 1, 0, 1);
      cyc(1, 16'h1234, 2'b11, 2'b11, 7'h3, 1, 1, 1, 0, 1);
      chk("rst_rxstate", rxstate, 128'h0);
      chk("rst_valid", rx_valid, 1'b0);
      idle(0);

      // Full 8-beat word.
      for (int i = 1; i <= 8; i++) send(16'(i), 2'b11, 7'h0, 0, i == 8);
      chk("full_state", rxstate, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      chk("full_bytes", rx_bytes, 5'd16);
      chk("full_last", rx_last, 1'b1);
      chk("full_err", rx_err, 1'b0);

      // Backpressure: beat offered during HOLD, rx_ready after 4 cycles.
      for (int i = 0; i < 4; i++) cyc(1, 16'hAAAA, 2'b11, 2'b11, 7'h0, 0, 0, 0, 0, 0);
      cyc(1, 16'hAAAA, 2'b11, 2'b11, 7'h0, 0, 0, 0, 1, 0);
      chk("bp_released", rx_valid, 1'b0);
      send(16'hAAAA, 2'b11, 7'h0, 0, 0);
      idle(0);
      send(16'hBBBB, 2'b11, 7'h0, 0, 0);
      idle(0);
      send(16'hCCCC, 2'b11, 7'h0, 0, 1);
      chk("bp_state", rxstate, 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA);
      chk("bp_bytes", rx_bytes, 5'd6);
      idle(1);

      // Short packet with partial final beat.
      send(16'd10000, 2'b11, 7'h0, 0, 0);
      send(16'd9999, 2'b11, 7'h0, 0, 0);
      send(16'd9998, 2'b01, 7'h0, 0, 1);
      chk("short_state", rxstate, 128'h000E_270F_2710);
      chk("short_bytes", rx_bytes, 5'd5);
      chk("short_last", rx_last, 1'b1);
      idle(1);

      // Error cases.
      send(16'h1111, 2'b11, 7'h05, 0, 0);
      send(16'h2222, 2'b11, 7'h06, 0, 1);
      chk("err_tid", rx_err, 1'b1);
      idle(1);
      send(16'h3333, 2'b01, 7'h0, 0, 0);
      send(16'h4444, 2'b11, 7'h0, 0, 1);
      chk("err_keep", rx_err, 1'b1);
      idle(1);
      for (int i = 0; i < 4; i++) send(16'h5550 + 16'(i), 2'b11, 7'h0, i == 2, i == 3);
      chk("user_set", rx_user, 1'b1);
      chk("user_noerr", rx_err, 1'b0);
      idle(1);
      send(16'h6666, 2'b11, 7'h0, 0, 0);
      send(16'h7777, 2'b11, 7'h0, 0, 1);
      chk("clean_err", rx_err, 1'b0);
      chk("clean_user", rx_user, 1'b0);
      idle(1);

      // Mid-word reset discards the partial word.
      for (int i = 0; i < 3; i++) send(16'hE000 + 16'(i), 2'b11, 7'h0, 0, 0);
      cyc(1, 16'hDEAD, 2'b11, 2'b11, 7'h0, 0, 0, 0, 0, 1);
      chk("mid_rst_valid", rx_valid, 1'b0);
      for (int i = 0; i < 8; i++) send(16'hF000 + 16'(i), 2'b11, 7'h0, 0, 0);
      chk("post_rst_lane0", rxstate[15:0], 16'hF000);
      chk("post_rst_bytes", rx_bytes, 5'd16);
      chk("post_rst_last", rx_last, 1'b0);
      idle(1);

      // Randomized stream.
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] kp;
         logic [6:0] id;
         kp = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
         id = ($urandom_range(0, 19) == 0) ? 7'($urandom) : 7'h11;
         cyc($urandom_range(0, 9) < 7, 16'($urandom), kp, 2'($urandom), id,
             $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 99) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
